// File: rtl/fp32_acc_pkg.sv
// Shared types and constants for the FP32 product accumulator.
package fp32_acc_pkg;

    localparam int EXP_W         = 8;
    localparam int FRAC_W        = 23;
    localparam int MANT_W        = 24;
    localparam int ALIGN_CAP_DEF = 26;

    localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
    localparam logic [31:0]      FP32_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_t;

    // Signed infinity encoding.
    function automatic logic [31:0] fp32_inf(input logic sign);
        return {sign, EXP_MAX, {FRAC_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fp32_acc_unpack.sv
// Combinational FP32 field splitter; denormals are flushed to zero.
module fp32_unpack
    import fp32_acc_pkg::*;
(
    input  logic [31:0]       word,
    output logic              sign,
    output logic [EXP_W-1:0]  exponent,
    output logic [MANT_W-1:0] mant,
    output logic              is_zero,
    output logic              is_inf
);

    assign sign     = word[31];
    assign exponent = word[30:23];
    assign is_zero  = (word[30:23] == '0);
    assign is_inf   = (word[30:23] == EXP_MAX);
    // Hidden bit restored only for nonzero operands.
    assign mant     = is_zero ? '0 : {1'b1, word[FRAC_W-1:0]};

endmodule

// File: rtl/fp32_product_accumulator.sv
// Serial FP32 accumulator: sums NUM_TERMS products with one-bit-per-cycle
// alignment and normalisation, truncating rounding, result on a handshake.
module fp32_product_accumulator
    import fp32_acc_pkg::*;
#(
    parameter int NUM_TERMS = 4,
    parameter int ALIGN_CAP = ALIGN_CAP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] in_data,
    input  logic        in_ready,
    output logic        in_accept,
    output logic [31:0] acc_out,
    output logic        out_ready,
    input  logic        out_accept,
    output logic        busy
);

    localparam logic [EXP_W-1:0] CAP      = EXP_W'(ALIGN_CAP);
    localparam logic [7:0]       LAST_CNT = 8'(NUM_TERMS - 1);

    state_t             state;
    logic [31:0]        acc;
    logic [31:0]        opnd;
    logic [7:0]         count;
    logic [MANT_W:0]    mant_l;     // larger-exponent operand
    logic [MANT_W:0]    mant_s;     // smaller-exponent operand, being aligned
    logic               sign_l;
    logic               sign_s;
    logic [EXP_W-1:0]   exp_r;
    logic [EXP_W-1:0]   align_cnt;
    logic [MANT_W:0]    res;
    logic               res_sign;

    logic               ua_sign, ub_sign, ua_zero, ub_zero, ua_inf, ub_inf;
    logic [EXP_W-1:0]   ua_exp, ub_exp;
    logic [MANT_W-1:0]  ua_mant, ub_mant;

    fp32_unpack u_unpack_acc (
        .word(acc), .sign(ua_sign), .exponent(ua_exp), .mant(ua_mant),
        .is_zero(ua_zero), .is_inf(ua_inf)
    );

    fp32_unpack u_unpack_opnd (
        .word(opnd), .sign(ub_sign), .exponent(ub_exp), .mant(ub_mant),
        .is_zero(ub_zero), .is_inf(ub_inf)
    );

    logic               a_ge_b;
    logic [EXP_W-1:0]   diff;
    logic [MANT_W:0]    add_mag;
    logic               add_sign;
    logic               fin;
    logic [31:0]        fin_val;
    logic               last;

    assign a_ge_b = (ua_exp >= ub_exp);
    assign diff   = a_ge_b ? (ua_exp - ub_exp) : (ub_exp - ua_exp);
    assign last   = (count == LAST_CNT);
    assign busy   = (state != S_IDLE) && (state != S_DONE);

    // Sign-magnitude add: larger magnitude minus smaller when signs differ.
    always_comb begin
        add_mag  = mant_l + mant_s;
        add_sign = sign_l;
        if (sign_l != sign_s) begin
            if (mant_l >= mant_s) begin
                add_mag  = mant_l - mant_s;
                add_sign = sign_l;
            end else begin
                add_mag  = mant_s - mant_l;
                add_sign = sign_s;
            end
        end
    end

    // Detect the cycle that completes a term and the value to write back.
    always_comb begin
        fin     = 1'b0;
        fin_val = acc;
        case (state)
            S_LOAD: begin
                if (ua_inf) begin
                    fin     = 1'b1;          // first infinity wins
                    fin_val = acc;
                end else if (ub_inf) begin
                    fin     = 1'b1;
                    fin_val = fp32_inf(ub_sign);
                end
            end
            S_ADD: begin
                if (add_mag == '0) begin
                    fin     = 1'b1;          // exact cancellation is +0
                    fin_val = FP32_ZERO;
                end
            end
            S_NORM: begin
                if (res[MANT_W]) begin
                    if (exp_r >= EXP_MAX - 8'd1) begin
                        fin     = 1'b1;
                        fin_val = fp32_inf(res_sign);
                    end
                end else if (res[MANT_W-1]) begin
                    fin     = 1'b1;
                    fin_val = {res_sign, exp_r, res[FRAC_W-1:0]};
                end else if (exp_r == 8'd1) begin
                    fin     = 1'b1;          // would underflow: flush
                    fin_val = FP32_ZERO;
                end
            end
            default: ;
        endcase
    end

    // Main FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= FP32_ZERO;
            opnd      <= '0;
            count     <= '0;
            mant_l    <= '0;
            mant_s    <= '0;
            sign_l    <= 1'b0;
            sign_s    <= 1'b0;
            exp_r     <= '0;
            align_cnt <= '0;
            res       <= '0;
            res_sign  <= 1'b0;
            in_accept <= 1'b0;
            out_ready <= 1'b0;
            acc_out   <= '0;
        end else begin
            in_accept <= 1'b0;
            if (clear) begin
                state     <= S_IDLE;
                acc       <= FP32_ZERO;
                count     <= '0;
                out_ready <= 1'b0;
            end else if (fin) begin
                acc   <= fin_val;
                count <= count + 8'd1;
                if (last) begin
                    state     <= S_DONE;
                    out_ready <= 1'b1;
                    acc_out   <= fin_val;
                end else begin
                    state <= S_IDLE;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (in_ready) begin
                            in_accept <= 1'b1;
                            opnd      <= in_data;
                            state     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (ua_zero || ub_zero) begin
                            // One side is zero: pass the other straight through.
                            mant_l <= {1'b0, ua_mant | ub_mant};
                            mant_s <= '0;
                            sign_l <= ua_zero ? ub_sign : ua_sign;
                            sign_s <= ua_zero ? ub_sign : ua_sign;
                            exp_r  <= ua_zero ? ub_exp : ua_exp;
                            state  <= S_ADD;
                        end else begin
                            mant_l    <= {1'b0, a_ge_b ? ua_mant : ub_mant};
                            sign_l    <= a_ge_b ? ua_sign : ub_sign;
                            sign_s    <= a_ge_b ? ub_sign : ua_sign;
                            exp_r     <= a_ge_b ? ua_exp : ub_exp;
                            mant_s    <= (diff >= CAP) ? '0
                                         : {1'b0, a_ge_b ? ub_mant : ua_mant};
                            align_cnt <= diff;
                            state     <= (diff == '0 || diff >= CAP) ? S_ADD : S_ALIGN;
                        end
                    end
                    S_ALIGN: begin
                        mant_s    <= mant_s >> 1;
                        align_cnt <= align_cnt - 8'd1;
                        if (align_cnt == 8'd1)
                            state <= S_ADD;
                    end
                    S_ADD: begin
                        res      <= add_mag;
                        res_sign <= add_sign;
                        state    <= S_NORM;
                    end
                    S_NORM: begin
                        if (res[MANT_W]) begin
                            res   <= res >> 1;
                            exp_r <= exp_r + 8'd1;
                        end else begin
                            res   <= res << 1;
                            exp_r <= exp_r - 8'd1;
                        end
                    end
                    S_DONE: begin
                        if (out_accept) begin
                            out_ready <= 1'b0;
                            acc       <= FP32_ZERO;
                            count     <= '0;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
